id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register of the 5-stage RV32 core, directly downstream of the register file. It captures the decoded instruction and both register-file read operands at the end of ID, and repairs same-cycle write-back collisions with a WB bypass. It inserts load-use bubbles and honours pipeline stall and branch flush. It is the sole source of operands and control for the EX stage.

## Interface
- `XLEN`, default 32: datapath width.
- `CTRL_W`, default 12: control bundle width.
  - bit 0 = RegWrite.
  - bit 1 = MemRead.
  - bit 2 = MemWrite.
  - Remaining bits are opaque and passed through.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold request from downstream. IF/ID/EX freeze; MEM/WB keep draining.
- `flush`  in  1  branch/jump redirect resolved in EX; kills the instruction entering EX.
- `id_valid`  in  1  the ID slot holds a real instruction.
- `id_pc`  in  XLEN  PC of the ID instruction.
- `id_imm`  in  XLEN  sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register addresses.
- `id_rdata1`, `id_rdata2`  in  XLEN each  register-file read data.
- `id_ctrl`  in  CTRL_W  decoded control bundle.
- `wb_reg_write`  in  1  WB stage writes the register file this cycle.
- `wb_rd`  in  5  WB destination register.
- `wb_data`  in  XLEN  WB write data.
- `ex_valid`  out  1  the EX slot holds a real instruction.
- `ex_pc`, `ex_imm`  out  XLEN each  registered copies of `id_pc` and `id_imm`.
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5 each  registered register addresses.
- `ex_rdata1`, `ex_rdata2`  out  XLEN each  registered, bypass-corrected operands.
- `ex_ctrl`  out  CTRL_W  registered control bundle.
- `load_use_hazard`  out  1  combinational. Upstream holds PC and IF/ID while this is high.

## Operation
Operand selection for operand n (n = 1, 2):
- If `id_rs`n == 0, the operand is 0.
- Else if `wb_reg_write` & `wb_rd` != 0 & `wb_rd` == `id_rs`n, the operand is `wb_data`. The register file writes on the same edge, so its read data is stale this cycle.
- Otherwise the operand is `id_rdata`n.

Load-use hazard:
- `load_use_hazard` = `ex_valid` & `ex_ctrl[1]` & `ex_rd` != 0 & `id_valid` & ~`flush` & (`ex_rd` == `id_rs1` | `ex_rd` == `id_rs2`).
- rs2 is compared regardless of instruction format (conservative).

Per-edge action, first match wins:
1. `flush`: load a bubble. All ex_* outputs are 0, including `ex_valid` = 0.
2. `stall`: hold every field, with one exception: held `ex_rdata`n is replaced by `wb_data` when `wb_reg_write` & `wb_rd` != 0 & `wb_rd` == `ex_rs`n. This is required because WB keeps retiring older instructions during a stall.
3. `load_use_hazard`: load a bubble. The ID instruction is re-presented on the next cycle by the held IF/ID.
4. `id_valid` == 0: load a bubble.
5. Otherwise: load all id_* fields with the selected operands, and set `ex_valid` = 1.

Other rules:
- A bubble never writes registers or memory; `ex_ctrl` is all-zero.
- No arithmetic is performed; all widths pass through unchanged.

## Timing
- Reset: while `rst` = 0, every ex_* output is 0 immediately (asynchronous), and therefore `load_use_hazard` = 0.
  - Reset release takes effect at the first rising edge with `rst` = 1.
  - Reset asserted mid-stall or mid-hazard discards the held instruction.
- Latency: one cycle from ID inputs to ex_* outputs.
- `load_use_hazard` is purely combinational from current ex_* and id_* values; there is no registered delay.
- A load followed immediately by a dependent instruction:
  - Cycle N: the load is in EX and `load_use_hazard` = 1.
  - Edge N: a bubble enters EX.
  - Cycle N+1: hazard = 0.
  - Edge N+1: the dependent instruction enters EX. Its operand comes from the EX/MEM forwarding unit downstream, not from this block.
- Simultaneous events:
  - `flush` + `stall` → flush.
  - `stall` + hazard → hold, and the hazard stays asserted.
  - WB bypass and ID capture happen on the same edge.

## Test plan
- Reset: drive `rst` = 0 mid-cycle with `ex_valid` = 1 and `ex_rdata1` = 0x5 → all outputs are 0 before the next edge, and stay 0 until the first edge after release.
- Normal capture:
  - Stimulus: `id_valid` = 1, pc = 0x100, rs1 = 3, rs2 = 4, rd = 5, rdata 0x11/0x22, ctrl = 0x001.
  - Response: next cycle `ex_*` mirror these values and `ex_valid` = 1.
- WB bypass:
  - Stimulus: `id_rs1` = 7, `id_rdata1` = 0xAAAA, `wb_reg_write` = 1, `wb_rd` = 7, `wb_data` = 0x1234.
  - Response: `ex_rdata1` = 0x1234.
  - Repeat with `wb_rd` = 0 → `ex_rdata1` = 0xAAAA.
  - Repeat with `id_rs1` = 0 → `ex_rdata1` = 0.
- Load-use:
  - Stimulus: EX holds a load with rd = 6 (`ex_ctrl[1]` = 1); ID holds rs2 = 6.
  - Response: `load_use_hazard` = 1; next cycle `ex_valid` = 0 and `ex_ctrl` = 0, and hazard = 0.
  - Same setup with `flush` = 1 → hazard = 0 and a bubble is loaded.
- Stall:
  - Stimulus: hold `stall` = 1 for 3 cycles with `ex_rs2` = 9 and changing id_* inputs; in cycle 2, pulse `wb_reg_write`, `wb_rd` = 9, `wb_data` = 0xBEEF.
  - Response: all fields are unchanged except `ex_rdata2` = 0xBEEF from cycle 3 onward.
- Flush priority:
  - Stimulus: `flush` = 1 together with `stall` = 1 and `id_valid` = 1.
  - Response: the next cycle is a bubble, with all ex_* = 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded instruction and operands, applies WB bypass,
// inserts load-use / flush bubbles, and holds on stall while still absorbing WB retirements.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_rdata1,
    input  logic [XLEN-1:0]   id_rdata2,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [XLEN-1:0]   ex_rdata1,
    output logic [XLEN-1:0]   ex_rdata2,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              load_use_hazard
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [XLEN-1:0]   rdata1;
        logic [XLEN-1:0]   rdata2;
        logic [CTRL_W-1:0] ctrl;
    } ex_t;

    ex_t ex_q, ex_d;

    function automatic logic wb_hit(input logic we, input logic [4:0] wrd, input logic [4:0] rs);
        return we && (wrd != 5'd0) && (wrd == rs);
    endfunction

    // x0 reads as zero; a same-edge WB write beats the stale regfile read
    function automatic logic [XLEN-1:0] opsel(input logic [4:0] rs, input logic hit,
                                              input logic [XLEN-1:0] wdat,
                                              input logic [XLEN-1:0] rdat);
        if (rs == 5'd0) return '0;
        if (hit)        return wdat;
        return rdat;
    endfunction

    logic hit_id1, hit_id2, hit_ex1, hit_ex2;
    assign hit_id1 = wb_hit(wb_reg_write, wb_rd, id_rs1);
    assign hit_id2 = wb_hit(wb_reg_write, wb_rd, id_rs2);
    assign hit_ex1 = wb_hit(wb_reg_write, wb_rd, ex_q.rs1);
    assign hit_ex2 = wb_hit(wb_reg_write, wb_rd, ex_q.rs2);

    assign load_use_hazard = ex_q.valid && ex_q.ctrl[1] && (ex_q.rd != 5'd0) && id_valid && !flush
                          && ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

    always_comb begin
        ex_d = '0;
        if (flush) begin
            ex_d = '0;
        end else if (stall) begin
            // held operands must still see WB retirements of older instructions
            ex_d = ex_q;
            if (hit_ex1) ex_d.rdata1 = wb_data;
            if (hit_ex2) ex_d.rdata2 = wb_data;
        end else if (load_use_hazard || !id_valid) begin
            ex_d = '0;
        end else begin
            ex_d.valid  = 1'b1;
            ex_d.pc     = id_pc;
            ex_d.imm    = id_imm;
            ex_d.rs1    = id_rs1;
            ex_d.rs2    = id_rs2;
            ex_d.rd     = id_rd;
            ex_d.rdata1 = opsel(id_rs1, hit_id1, wb_data, id_rdata1);
            ex_d.rdata2 = opsel(id_rs2, hit_id2, wb_data, id_rdata2);
            ex_d.ctrl   = id_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ex_q <= '0;
        else      ex_q <= ex_d;
    end

    assign ex_valid  = ex_q.valid;
    assign ex_pc     = ex_q.pc;
    assign ex_imm    = ex_q.imm;
    assign ex_rs1    = ex_q.rs1;
    assign ex_rs2    = ex_q.rs2;
    assign ex_rd     = ex_q.rd;
    assign ex_rdata1 = ex_q.rdata1;
    assign ex_rdata2 = ex_q.rdata2;
    assign ex_ctrl   = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: reference model of the EX slot checked every negedge, plus
// directed scenarios with hand-computed expectations.
module tb_id_ex_stage;
    logic        clk = 0, rst = 0, stall = 0, flush = 0, id_valid = 0;
    logic [31:0] id_pc = 0, id_imm = 0, id_rdata1 = 0, id_rdata2 = 0;
    logic [4:0]  id_rs1 = 0, id_rs2 = 0, id_rd = 0;
    logic [11:0] id_ctrl = 0;
    logic        wb_reg_write = 0;
    logic [4:0]  wb_rd = 0;
    logic [31:0] wb_data = 0;
    logic        ex_valid, load_use_hazard;
    logic [31:0] ex_pc, ex_imm, ex_rdata1, ex_rdata2;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [11:0] ex_ctrl;

    int tests = 0, fails = 0;

    id_ex_stage #(.XLEN(32), .CTRL_W(12)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_ctrl(id_ctrl),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
        .ex_ctrl(ex_ctrl), .load_use_hazard(load_use_hazard)
    );

    always #5 clk = ~clk;

    // Model: the instruction record sitting in EX
    typedef struct {
        bit        v;
        bit [31:0] pc, imm, d1, d2;
        bit [4:0]  rs1, rs2, rd;
        bit [11:0] ctrl;
    } slot_t;
    slot_t m;

    function automatic bit m_haz();
        return m.v && m.ctrl[1] && m.rd != 0 && id_valid && !flush
            && (m.rd == id_rs1 || m.rd == id_rs2);
    endfunction

    function automatic bit [31:0] wb_view(bit [4:0] rs, bit [31:0] stale);
        if (rs == 0) return 0;
        if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return wb_data;
        return stale;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '{default: 0};
        else if (flush) m <= '{default: 0};
        else if (stall) begin
            if (wb_reg_write && wb_rd != 0 && wb_rd == m.rs1) m.d1 <= wb_data;
            if (wb_reg_write && wb_rd != 0 && wb_rd == m.rs2) m.d2 <= wb_data;
        end else if (m_haz() || !id_valid) m <= '{default: 0};
        else m <= '{v: 1, pc: id_pc, imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                    d1: wb_view(id_rs1, id_rdata1), d2: wb_view(id_rs2, id_rdata2),
                    ctrl: id_ctrl};
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic set_id(bit v, bit [31:0] pc, bit [4:0] r1, bit [4:0] r2, bit [4:0] rd,
                          bit [31:0] d1, bit [31:0] d2, bit [11:0] c);
        id_valid = v; id_pc = pc; id_imm = pc + 32'h4; id_rs1 = r1; id_rs2 = r2;
        id_rd = rd; id_rdata1 = d1; id_rdata2 = d2; id_ctrl = c;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                chk("m.valid", {31'b0, ex_valid}, {31'b0, m.v});
                chk("m.pc", ex_pc, m.pc);
                chk("m.imm", ex_imm, m.imm);
                chk("m.rs1", {27'b0, ex_rs1}, {27'b0, m.rs1});
                chk("m.rs2", {27'b0, ex_rs2}, {27'b0, m.rs2});
                chk("m.rd", {27'b0, ex_rd}, {27'b0, m.rd});
                chk("m.rdata1", ex_rdata1, m.d1);
                chk("m.rdata2", ex_rdata2, m.d2);
                chk("m.ctrl", {20'b0, ex_ctrl}, {20'b0, m.ctrl});
                chk("m.hazard", {31'b0, load_use_hazard}, {31'b0, m_haz()});
            end
            begin
                tick();
                chk("rst.valid", {31'b0, ex_valid}, 0);
                tick();
                rst = 1;

                // normal capture
                set_id(1, 32'h100, 3, 4, 5, 32'h11, 32'h22, 12'h001);
                tick();
                chk("cap.valid", {31'b0, ex_valid}, 1);
                chk("cap.pc", ex_pc, 32'h100);
                chk("cap.imm", ex_imm, 32'h104);
                chk("cap.rd", {27'b0, ex_rd}, 5);
                chk("cap.rdata1", ex_rdata1, 32'h11);
                chk("cap.rdata2", ex_rdata2, 32'h22);
                chk("cap.ctrl", {20'b0, ex_ctrl}, 32'h001);

                // asynchronous reset mid-cycle
                set_id(1, 32'h200, 3, 4, 5, 32'h5, 32'h6, 12'h001);
                tick();
                chk("pre_rst.rdata1", ex_rdata1, 32'h5);
                #1 rst = 0;
                #1;
                chk("arst.valid", {31'b0, ex_valid}, 0);
                chk("arst.rdata1", ex_rdata1, 0);
                chk("arst.pc", ex_pc, 0);
                tick();
                chk("arst_edge.valid", {31'b0, ex_valid}, 0);
                rst = 1;
                #1 chk("rel.valid", {31'b0, ex_valid}, 0);
                tick();
                chk("rel_edge.valid", {31'b0, ex_valid}, 1);

                // WB bypass variants
                set_id(1, 32'h300, 7, 0, 1, 32'hAAAA, 32'hBBBB, 12'h001);
                wb_reg_write = 1; wb_rd = 7; wb_data = 32'h1234;
                tick();
                chk("byp.rdata1", ex_rdata1, 32'h1234);
                chk("byp.rdata2_x0", ex_rdata2, 0);
                wb_rd = 0;
                tick();
                chk("byp_rd0.rdata1", ex_rdata1, 32'hAAAA);
                wb_rd = 7; id_rs1 = 0;
                tick();
                chk("byp_rs0.rdata1", ex_rdata1, 0);
                wb_reg_write = 0;

                // load-use bubble
                set_id(1, 32'h400, 1, 2, 6, 32'h1, 32'h2, 12'h003);
                tick();
                set_id(1, 32'h404, 8, 6, 9, 32'h8, 32'h66, 12'h001);
                #1 chk("lu.hazard", {31'b0, load_use_hazard}, 1);
                tick();
                chk("lu.bubble_valid", {31'b0, ex_valid}, 0);
                chk("lu.bubble_ctrl", {20'b0, ex_ctrl}, 0);
                chk("lu.hazard_after", {31'b0, load_use_hazard}, 0);
                tick();
                chk("lu.dep_valid", {31'b0, ex_valid}, 1);
                chk("lu.dep_pc", ex_pc, 32'h404);

                // load-use masked by flush
                set_id(1, 32'h500, 1, 2, 6, 32'h1, 32'h2, 12'h003);
                tick();
                set_id(1, 32'h504, 8, 6, 9, 32'h8, 32'h66, 12'h001);
                flush = 1;
                #1 chk("luf.hazard", {31'b0, load_use_hazard}, 0);
                tick();
                flush = 0;
                chk("luf.valid", {31'b0, ex_valid}, 0);

                // stall with WB retirement into held rs2
                set_id(1, 32'h600, 2, 9, 3, 32'h44, 32'h55, 12'h001);
                tick();
                stall = 1;
                set_id(1, 32'h700, 9, 9, 4, 32'h77, 32'h88, 12'h005);
                tick();
                chk("stl1.pc", ex_pc, 32'h600);
                chk("stl1.rdata2", ex_rdata2, 32'h55);
                wb_reg_write = 1; wb_rd = 9; wb_data = 32'hBEEF;
                tick();
                wb_reg_write = 0; id_pc = 32'h800;
                chk("stl2.rdata2", ex_rdata2, 32'hBEEF);
                chk("stl2.rdata1", ex_rdata1, 32'h44);
                tick();
                chk("stl3.rdata2", ex_rdata2, 32'hBEEF);
                chk("stl3.pc", ex_pc, 32'h600);
                chk("stl3.ctrl", {20'b0, ex_ctrl}, 32'h001);
                stall = 0;

                // stall + hazard: hold and keep hazard asserted
                set_id(1, 32'h900, 1, 2, 6, 32'h1, 32'h2, 12'h003);
                tick();
                stall = 1;
                set_id(1, 32'h904, 6, 0, 9, 32'h8, 32'h0, 12'h001);
                tick();
                chk("sh.valid", {31'b0, ex_valid}, 1);
                chk("sh.pc", ex_pc, 32'h900);
                chk("sh.hazard", {31'b0, load_use_hazard}, 1);

                // flush beats stall
                flush = 1;
                tick();
                chk("fp.valid", {31'b0, ex_valid}, 0);
                chk("fp.pc", ex_pc, 0);
                chk("fp.rdata1", ex_rdata1, 0);
                flush = 0; stall = 0;

                // mixed vectors with small register numbers for collisions
                for (int i = 0; i < 24; i++) begin
                    set_id($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 5)),
                           5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                           $urandom, $urandom, 12'($urandom));
                    stall = ($urandom_range(0, 3) == 0);
                    flush = ($urandom_range(0, 7) == 0);
                    wb_reg_write = $urandom_range(0, 1);
                    wb_rd = 5'($urandom_range(0, 5));
                    wb_data = $urandom;
                    tick();
                end
                stall = 0; flush = 0; wb_reg_write = 0;
                tick();
            end
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
